// File: rtl/sram_port_arbiter.sv
// Two-port request arbiter and sequencer for the single-transaction SRAM controller.
// Port 1 (GDP) has priority; port 0 (UART) is guaranteed a grant after STARVE_LIMIT losses.
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_wr,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic [15:0] p0_rdata,
    output logic        p0_done,
    output logic        p0_busy,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_wr,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic [15:0] p1_rdata,
    output logic        p1_done,
    output logic        p1_busy,
    output logic        p1_err,
    input  logic        err_clr,
    output logic        c_req,
    output logic        c_wr,
    output logic [15:0] c_addr,
    output logic [15:0] c_wdata,
    input  logic [15:0] c_rdata,
    input  logic        c_valid,
    input  logic        c_busy,
    output logic        grant,
    output logic [1:0]  fsm_state
);

    // Handshakes: pN_req is a one-cycle pulse, accepted only while that port is not busy
    // (otherwise dropped and flagged in pN_err). c_req is a one-cycle strobe in ISSUE,
    // launched only after c_busy was seen low in IDLE; c_valid is honoured only in WAIT.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        pend0;
    logic        pend1;
    logic        h0_wr;
    logic [15:0] h0_addr;
    logic [15:0] h0_wdata;
    logic        h1_wr;
    logic [15:0] h1_addr;
    logic [15:0] h1_wdata;
    logic [3:0]  starve_cnt;
    logic [7:0]  tmo_cnt;

    logic        inflight0;
    logic        inflight1;
    logic        busy0;
    logic        busy1;
    logic        accept0;
    logic        accept1;
    logic        drop0;
    logic        drop1;
    logic        sel1;
    logic        start;
    logic        complete;
    logic        tmo_hit;
    logic        finish;

    assign inflight0 = (state != ST_IDLE) && !grant;
    assign inflight1 = (state != ST_IDLE) && grant;
    assign busy0     = pend0 || inflight0;
    assign busy1     = pend1 || inflight1;
    assign accept0   = p0_req && !busy0;
    assign accept1   = p1_req && !busy1;
    assign drop0     = p0_req && busy0;
    assign drop1     = p1_req && busy1;

    // Port 1 wins whenever it is pending, except when port 0 has hit the starvation bound.
    assign sel1     = pend1 && !(pend0 && (starve_cnt == 4'(STARVE_LIMIT)));
    assign start    = (state == ST_IDLE) && (pend0 || pend1) && !c_busy;
    assign complete = (state == ST_WAIT) && c_valid;
    assign tmo_hit  = (state == ST_WAIT) && !c_valid && (tmo_cnt == 8'(TIMEOUT - 1));
    assign finish   = complete || tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (finish) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        c_req     = (state == ST_ISSUE);
        p0_busy   = busy0;
        p1_busy   = busy1;
        fsm_state = state;
    end

    // Port 0 holding register and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend0    <= 1'b0;
            h0_wr    <= 1'b0;
            h0_addr  <= 16'h0000;
            h0_wdata <= 16'h0000;
        end else begin
            if (accept0) begin
                pend0    <= 1'b1;
                h0_wr    <= p0_wr;
                h0_addr  <= p0_addr;
                h0_wdata <= p0_wdata;
            end else if (start && !sel1) begin
                pend0 <= 1'b0;
            end
        end
    end

    // Port 1 holding register and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend1    <= 1'b0;
            h1_wr    <= 1'b0;
            h1_addr  <= 16'h0000;
            h1_wdata <= 16'h0000;
        end else begin
            if (accept1) begin
                pend1    <= 1'b1;
                h1_wr    <= p1_wr;
                h1_addr  <= p1_addr;
                h1_wdata <= p1_wdata;
            end else if (start && sel1) begin
                pend1 <= 1'b0;
            end
        end
    end

    // Command bus is captured at selection so it holds steady through WAIT and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant   <= 1'b0;
            c_wr    <= 1'b0;
            c_addr  <= 16'h0000;
            c_wdata <= 16'h0000;
        end else if (start) begin
            grant   <= sel1;
            c_wr    <= sel1 ? h1_wr    : h0_wr;
            c_addr  <= sel1 ? h1_addr  : h0_addr;
            c_wdata <= sel1 ? h1_wdata : h0_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (start && sel1 && pend0) begin
            starve_cnt <= starve_cnt + 4'd1;
        end else if (!pend0 || (start && !sel1)) begin
            starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 8'd0;
        end else if ((state == ST_WAIT) && !finish) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= 8'd0;
        end
    end

    // Completion routing: done pulses on success or abort, rdata only on read success.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_done  <= 1'b0;
            p1_done  <= 1'b0;
            p0_rdata <= 16'h0000;
            p1_rdata <= 16'h0000;
        end else begin
            p0_done <= finish && !grant;
            p1_done <= finish && grant;
            if (complete && !c_wr && !grant) begin
                p0_rdata <= c_rdata;
            end
            if (complete && !c_wr && grant) begin
                p1_rdata <= c_rdata;
            end
        end
    end

    // err_clr has priority over any simultaneous error event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_err <= 1'b0;
            p1_err <= 1'b0;
        end else if (err_clr) begin
            p0_err <= 1'b0;
            p1_err <= 1'b0;
        end else begin
            if (drop0 || (tmo_hit && !grant)) begin
                p0_err <= 1'b1;
            end
            if (drop1 || (tmo_hit && grant)) begin
                p1_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter: latency, priority, starvation bound,
// timeout abort, overrun drop and asynchronous reset.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req;
    logic        p0_wr;
    logic [15:0] p0_addr;
    logic [15:0] p0_wdata;
    logic [15:0] p0_rdata;
    logic        p0_done;
    logic        p0_busy;
    logic        p0_err;
    logic        p1_req;
    logic        p1_wr;
    logic [15:0] p1_addr;
    logic [15:0] p1_wdata;
    logic [15:0] p1_rdata;
    logic        p1_done;
    logic        p1_busy;
    logic        p1_err;
    logic        err_clr;
    logic        c_req;
    logic        c_wr;
    logic [15:0] c_addr;
    logic [15:0] c_wdata;
    logic [15:0] c_rdata;
    logic        c_valid;
    logic        c_busy;
    logic        grant;
    logic [1:0]  fsm_state;

    int n_cmp;
    int n_err;

    sram_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_busy(p0_busy), .p0_err(p0_err),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_busy(p1_busy), .p1_err(p1_err),
        .err_clr(err_clr),
        .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_valid(c_valid), .c_busy(c_busy),
        .grant(grant), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_creq(input string name);
        int n;
        n = 0;
        while (c_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (c_req !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: c_req=%b, required 1 within 20 cycles", name, c_req);
        end
    endtask

    task automatic complete(input logic [15:0] data);
        c_valid = 1'b1;
        c_rdata = data;
        tick();
        c_valid = 1'b0;
        c_rdata = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({c_req, grant, p0_busy, p1_busy, p0_done, p1_done, p0_err, p1_err} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {c_req, grant, p0_busy, p1_busy, p0_done, p1_done, p0_err, p1_err});
        end
        n_cmp++;
        if ({c_wr, c_addr, c_wdata, p0_rdata, p1_rdata} !== 65'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h, required 0",
                     {c_wr, c_addr, c_wdata, p0_rdata, p1_rdata});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (fsm_state !== 2'd0 || c_req !== 1'b0 || p0_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: state=%0d c_req=%b busy=%b, required 0 0 0",
                     fsm_state, c_req, p0_busy);
        end
    endtask

    task automatic test_single_read();
        p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 16'h1234; p0_wdata = 16'h0000;
        tick();
        p0_req = 1'b0;
        n_cmp++;
        if (p0_busy !== 1'b1 || c_req !== 1'b0) begin
            n_err++;
            $display("FAIL single_k1: busy=%b c_req=%b, required 1 0", p0_busy, c_req);
        end
        tick();
        n_cmp++;
        if (c_req !== 1'b1 || c_addr !== 16'h1234 || c_wr !== 1'b0 || grant !== 1'b0) begin
            n_err++;
            $display("FAIL single_issue: c_req=%b addr=%h wr=%b grant=%b, required 1 1234 0 0",
                     c_req, c_addr, c_wr, grant);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (p0_busy !== 1'b1 || c_req !== 1'b0 || p0_done !== 1'b0) begin
                n_err++;
                $display("FAIL single_wait%0d: busy=%b c_req=%b done=%b, required 1 0 0",
                         i, p0_busy, c_req, p0_done);
            end
        end
        complete(16'hBEEF);
        n_cmp++;
        if (p0_done !== 1'b1 || p0_rdata !== 16'hBEEF || p0_busy !== 1'b0 || p1_done !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: done=%b rdata=%h busy=%b p1_done=%b, required 1 beef 0 0",
                     p0_done, p0_rdata, p0_busy, p1_done);
        end
        tick();
        n_cmp++;
        if (p0_done !== 1'b0 || p0_rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL single_after: done=%b rdata=%h, required 0 beef", p0_done, p0_rdata);
        end
    endtask

    task automatic test_simultaneous();
        p0_req = 1'b1; p0_wr = 1'b1; p0_addr = 16'h0010; p0_wdata = 16'hAAAA;
        p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 16'h0020; p1_wdata = 16'h0000;
        tick();
        p0_req = 1'b0; p1_req = 1'b0;
        n_cmp++;
        if (p0_busy !== 1'b1 || p1_busy !== 1'b1) begin
            n_err++;
            $display("FAIL simul_busy: p0=%b p1=%b, required 1 1", p0_busy, p1_busy);
        end
        tick();
        n_cmp++;
        if (c_req !== 1'b1 || c_addr !== 16'h0020 || c_wr !== 1'b0 || grant !== 1'b1) begin
            n_err++;
            $display("FAIL simul_first: c_req=%b addr=%h wr=%b grant=%b, required 1 0020 0 1",
                     c_req, c_addr, c_wr, grant);
        end
        tick();
        complete(16'h5555);
        n_cmp++;
        if (p1_done !== 1'b1 || p0_done !== 1'b0 || p1_rdata !== 16'h5555) begin
            n_err++;
            $display("FAIL simul_done1: p1_done=%b p0_done=%b p1_rdata=%h, required 1 0 5555",
                     p1_done, p0_done, p1_rdata);
        end
        tick();
        n_cmp++;
        if (c_req !== 1'b1 || c_addr !== 16'h0010 || c_wr !== 1'b1 || c_wdata !== 16'hAAAA ||
            grant !== 1'b0) begin
            n_err++;
            $display("FAIL simul_second: c_req=%b addr=%h wr=%b wdata=%h grant=%b, required 1 0010 1 aaaa 0",
                     c_req, c_addr, c_wr, c_wdata, grant);
        end
        tick();
        complete(16'h9999);
        n_cmp++;
        if (p0_done !== 1'b1 || p1_done !== 1'b0 || p0_rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL simul_done2: p0_done=%b p1_done=%b p0_rdata=%h, required 1 0 beef",
                     p0_done, p1_done, p0_rdata);
        end
        tick();
        n_cmp++;
        if (p0_done !== 1'b0 || p1_done !== 1'b0 || p0_busy !== 1'b0 || p1_busy !== 1'b0) begin
            n_err++;
            $display("FAIL simul_quiet: done=%b%b busy=%b%b, required 00 00",
                     p0_done, p1_done, p0_busy, p1_busy);
        end
    endtask

    task automatic test_starvation();
        logic [5:0] exp_g;
        exp_g = 6'b101111;
        c_busy = 1'b1;
        p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 16'h0A00;
        p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 16'h0B00;
        tick();
        p0_req = 1'b0; p1_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            c_busy = 1'b0;
            wait_creq("starve_issue");
            n_cmp++;
            if (grant !== exp_g[i] || c_addr !== (exp_g[i] ? 16'h0B00 : 16'h0A00)) begin
                n_err++;
                $display("FAIL starve_grant%0d: grant=%b addr=%h, required %b %h", i, grant, c_addr,
                         exp_g[i], exp_g[i] ? 16'h0B00 : 16'h0A00);
            end
            c_busy = 1'b1;
            tick();
            complete(16'h1000 + 16'(i));
            n_cmp++;
            if (p1_done !== exp_g[i] || p0_done !== !exp_g[i]) begin
                n_err++;
                $display("FAIL starve_done%0d: p0_done=%b p1_done=%b, required %b %b", i,
                         p0_done, p1_done, !exp_g[i], exp_g[i]);
            end
            if (i < 4) begin
                p1_req = 1'b1; p1_addr = 16'h0B00;
                tick();
                p1_req = 1'b0;
            end
        end
        c_busy = 1'b0;
        n_cmp++;
        if (p0_rdata !== 16'h1004 || p1_rdata !== 16'h1005) begin
            n_err++;
            $display("FAIL starve_rdata: p0=%h p1=%h, required 1004 1005", p0_rdata, p1_rdata);
        end
    endtask

    task automatic test_timeout();
        p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 16'h0030;
        tick();
        p1_req = 1'b0;
        wait_creq("tmo_issue");
        repeat (64) tick();
        n_cmp++;
        if (p1_done !== 1'b0 || p1_busy !== 1'b1 || p1_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_last_wait: done=%b busy=%b err=%b, required 0 1 0",
                     p1_done, p1_busy, p1_err);
        end
        tick();
        n_cmp++;
        if (p1_done !== 1'b1 || p1_err !== 1'b1 || p1_busy !== 1'b0 || p1_rdata !== 16'h1005 ||
            p0_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_abort: done=%b err=%b busy=%b rdata=%h p0_err=%b, required 1 1 0 1005 0",
                     p1_done, p1_err, p1_busy, p1_rdata, p0_err);
        end
        complete(16'hDEAD);
        tick();
        n_cmp++;
        if (p1_done !== 1'b0 || p0_done !== 1'b0 || p1_rdata !== 16'h1005 || c_req !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_stray: done=%b%b rdata=%h c_req=%b, required 00 1005 0",
                     p0_done, p1_done, p1_rdata, c_req);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (p1_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_errclr: p1_err=%b, required 0", p1_err);
        end
    endtask

    task automatic test_overrun();
        int n_issue;
        p0_req = 1'b1; p0_wr = 1'b1; p0_addr = 16'h0040; p0_wdata = 16'h1111;
        tick();
        p0_addr = 16'h0050; p0_wdata = 16'h2222;
        tick();
        p0_req = 1'b0;
        n_cmp++;
        if (p0_err !== 1'b1 || c_req !== 1'b1 || c_addr !== 16'h0040 || c_wdata !== 16'h1111 ||
            c_wr !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_issue: err=%b c_req=%b addr=%h wdata=%h wr=%b, required 1 1 0040 1111 1",
                     p0_err, c_req, c_addr, c_wdata, c_wr);
        end
        tick();
        p0_req = 1'b1; p0_addr = 16'h0060; p0_wdata = 16'h3333; err_clr = 1'b1;
        tick();
        p0_req = 1'b0; err_clr = 1'b0;
        n_cmp++;
        if (p0_err !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clr_wins: p0_err=%b, required 0", p0_err);
        end
        complete(16'h7777);
        n_cmp++;
        if (p0_done !== 1'b1 || p0_rdata !== 16'h1004 || p0_busy !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_done: done=%b rdata=%h busy=%b, required 1 1004 0",
                     p0_done, p0_rdata, p0_busy);
        end
        n_issue = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (c_req === 1'b1) n_issue++;
        end
        n_cmp++;
        if (n_issue != 0) begin
            n_err++;
            $display("FAIL overrun_no_reissue: c_req seen %0d times, required 0", n_issue);
        end
    endtask

    task automatic test_reset_mid();
        p1_req = 1'b1; p1_wr = 1'b0; p1_addr = 16'h0088;
        tick();
        p1_req = 1'b0;
        wait_creq("rstmid_issue");
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({c_req, grant, p0_busy, p1_busy, p0_done, p1_done} !== 6'b0 || c_addr !== 16'h0000 ||
            p0_rdata !== 16'h0000 || p1_rdata !== 16'h0000) begin
            n_err++;
            $display("FAIL rstmid_async: flags=%b c_addr=%h rdata=%h/%h, required 000000 0000 0000/0000",
                     {c_req, grant, p0_busy, p1_busy, p0_done, p1_done}, c_addr, p0_rdata, p1_rdata);
        end
        tick();
        tick();
        n_cmp++;
        if (p1_done !== 1'b0 || c_req !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_nodone: p1_done=%b c_req=%b, required 0 0", p1_done, c_req);
        end
        rst_n = 1'b1;
        tick();
        p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 16'h0077;
        tick();
        p0_req = 1'b0;
        n_cmp++;
        if (p0_busy !== 1'b1 || c_req !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_k1: busy=%b c_req=%b, required 1 0", p0_busy, c_req);
        end
        tick();
        n_cmp++;
        if (c_req !== 1'b1 || c_addr !== 16'h0077 || grant !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_issue: c_req=%b addr=%h grant=%b, required 1 0077 0",
                     c_req, c_addr, grant);
        end
        tick();
        complete(16'h4242);
        n_cmp++;
        if (p0_done !== 1'b1 || p0_rdata !== 16'h4242) begin
            n_err++;
            $display("FAIL rstmid_done: done=%b rdata=%h, required 1 4242", p0_done, p0_rdata);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_wr = 1'b0; p0_addr = 16'h0000; p0_wdata = 16'h0000;
        p1_req = 1'b0; p1_wr = 1'b0; p1_addr = 16'h0000; p1_wdata = 16'h0000;
        err_clr = 1'b0; c_rdata = 16'h0000; c_valid = 1'b0; c_busy = 1'b0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port request arbiter and sequencer for the 125 MHz SRAM controller. It sits between the two CDC bridges (port 0 = UART control path, port 1 = GDP memory path) and the single-transaction SRAM controller. It latches one outstanding request per port and grants the controller with GDP priority plus a starvation bound for UART. It routes read data and completion back to the granted port, and aborts transactions the controller never completes.

## Interface
- STARVE_LIMIT, 4: consecutive port-1 grants allowed while port 0 is pending; 1..15.
- TIMEOUT, 64: cycles in WAIT before abort; 2..255.
- clk  in  1  125 MHz SRAM-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req / p1_req  in  1  single-cycle request pulse.
- p0_wr / p1_wr  in  1  1 = write, 0 = read; sampled with req.
- p0_addr / p1_addr  in  16  word address; sampled with req.
- p0_wdata / p1_wdata  in  16  write data; sampled with req.
- p0_rdata / p1_rdata  out  16  read data; held until that port's next read completion.
- p0_done / p1_done  out  1  one-cycle completion pulse.
- p0_busy / p1_busy  out  1  request pending or in flight.
- p0_err / p1_err  out  1  sticky: timeout or dropped request on that port.
- err_clr  in  1  clears both err bits.
- c_req  out  1  one-cycle command strobe to the controller.
- c_wr  out  1  command type.
- c_addr  out  16  command address.
- c_wdata  out  16  command write data.
- c_rdata  in  16  controller read data, valid with c_valid.
- c_valid  in  1  controller completion pulse.
- c_busy  in  1  controller cannot accept c_req.
- grant  out  1  port owning the current or last transaction.

## Operation
- Per port: holding register {wr, addr, wdata} plus pend flag. A req with pend=0 and the port not in flight loads the register and sets pend. A req while busy is dropped and sets that port's err; the holding register is unchanged.
- FSM states IDLE, ISSUE, WAIT.
- IDLE: if any pend and c_busy=0, select a port and go to ISSUE. Otherwise stay.
- Selection: port 1 wins unless (a) only port 0 is pending, or (b) port 0 is pending and starve_cnt == STARVE_LIMIT.
- starve_cnt (4 bit) increments on each port-1 grant while port 0 is pending. It clears on any port-0 grant, and when port 0 is not pending.
- ISSUE: c_req=1 for exactly this cycle. c_wr/c_addr/c_wdata are driven from the selected holding register. The selected pend clears. Next state is WAIT.
- WAIT: on c_valid, latch c_rdata into the granted port's rdata (reads only), pulse its done, and go to IDLE. Write completions leave rdata unchanged.
- Timeout: tmo_cnt reaches TIMEOUT−1 with no c_valid. Then go to IDLE, set the granted port's err, and pulse done. rdata is unchanged. A late c_valid arriving in IDLE/ISSUE is ignored.
- err_clr wins over a simultaneous err set.
- c_addr/c_wr/c_wdata hold their last values outside ISSUE.

## Timing
- Reset values: all outputs 0, including grant=0. Internally: pend=0, starve_cnt=0, tmo_cnt=0, state IDLE.
- Request at edge k sets pend at edge k; busy is high in the following cycle.
- With an idle arbiter and c_busy=0, c_req is high in cycle k+2, i.e. 2 cycles after the req cycle.
- c_valid sampled at edge m gives done high for cycle m+1 and rdata updated at m+1. busy falls in the same cycle.
- Back-to-back: the next c_req can be no earlier than 2 cycles after c_valid (via IDLE).
- Same-cycle requests on both ports: port 1 issues first, port 0 issues next, unless the starvation rule says otherwise.
- c_busy is sampled only in IDLE. Once in ISSUE, the strobe is emitted regardless of c_busy.
- Reset mid-transaction clears everything immediately. There is no done for the aborted transaction.

## Test plan
- Single read, port 0, addr 0x1234: controller returns 0xBEEF 3 cycles after c_req -> c_req at req+2; p0_done one cycle; p0_rdata=0xBEEF; p0_busy high throughout, then low; grant=0.
- Simultaneous p0 write 0x0010/0xAAAA and p1 read 0x0020 -> first c_req has addr 0x0020 and grant=1; second has addr 0x0010, wr=1, wdata 0xAAAA; both done pulses appear once.
- Starvation, STARVE_LIMIT=4: port 0 pending while port 1 re-requests every completion -> exactly 4 port-1 grants, then a port-0 grant, then port 1 resumes.
- Timeout, TIMEOUT=64: c_valid withheld -> abort after 64 WAIT cycles; p1_done pulses; p1_err=1; rdata unchanged; a later stray c_valid has no effect; err_clr drops p1_err.
- Overrun: second p0_req while p0_busy -> p0_err=1; the original request completes with its original addr/data; the dropped one is never issued.
- Reset asserted in WAIT -> all outputs 0 asynchronously. After release, a new request works with normal 2-cycle issue latency.
